// File: rtl/ic_order_gen.sv
// ic_order_gen: consumer side of the Ichimoku signal pair. Confirms buy/sell
// samples over CONFIRM consecutive strobes, tracks a long/flat position and
// issues single-lot orders over a valid/ready handshake.
// Optional feature macro: IC_ORDER_TIMEOUT_EN (abandon an order after TIMEOUT
// cycles without order_ready).
module ic_order_gen #(
  parameter int unsigned CONFIRM  = 3,
  parameter int unsigned COOLDOWN = 4,
  parameter logic [15:0] QTY      = 16'd100,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_valid,
  input  logic        sig_out1,
  input  logic        sig_out2,
  input  logic [31:0] price,
  input  logic        order_ready,
  output logic        order_valid,
  output logic        order_side,
  output logic [15:0] order_qty,
  output logic [31:0] order_price,
  output logic        long_pos,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {StFlat, StLong, StPendBuy, StPendSell, StCool} state_e;

  localparam logic [1:0] CodeBuy  = 2'b10;
  localparam logic [1:0] CodeSell = 2'b00;
  localparam logic [1:0] CodeHold = 2'b01;
  localparam logic [1:0] CodeIll  = 2'b11;

  localparam logic [3:0] ConfirmW  = CONFIRM[3:0];
  localparam logic [7:0] CooldownW = COOLDOWN[7:0];

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_cool, w_cool_nxt;
  logic [1:0]  r_last, w_last_nxt;
  logic        r_side, w_side_nxt;
  logic [31:0] r_price, w_price_nxt;
  logic        r_long, w_long_nxt;
  logic [7:0]  r_err, w_err_nxt;

  logic [1:0]  w_code;
  logic        w_actionable;
  logic [3:0]  w_cnt_inc;
  state_e      w_rest_state;

`ifdef IC_ORDER_TIMEOUT_EN
  localparam int unsigned TmoLastI = TIMEOUT - 1;
  localparam logic [15:0] TmoLast  = TmoLastI[15:0];
  logic [15:0] r_wait, w_wait_nxt;
`endif

  assign w_code       = {sig_out1, sig_out2};
  assign w_actionable = ((r_state == StFlat) && (w_code == CodeBuy)) ||
                        ((r_state == StLong) && (w_code == CodeSell));
  // A candidate different from the last one restarts the run at 1.
  assign w_cnt_inc    = (w_code == r_last) ? (r_cnt + 4'd1) : 4'd1;
  assign w_rest_state = r_long ? StLong : StFlat;

  // Next-state logic for the order FSM and all datapath registers.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cool_nxt  = r_cool;
    w_last_nxt  = r_last;
    w_side_nxt  = r_side;
    w_price_nxt = r_price;
    w_long_nxt  = r_long;
    w_err_nxt   = r_err;
`ifdef IC_ORDER_TIMEOUT_EN
    w_wait_nxt  = '0;
`endif
    unique case (r_state)
      StFlat, StLong: begin
        if (sig_valid) begin
          if ((w_code == CodeIll) && (r_err != 8'hFF)) begin
            w_err_nxt = r_err + 8'd1;
          end
          if (w_actionable) begin
            w_last_nxt = w_code;
            if (w_cnt_inc == ConfirmW) begin
              w_cnt_nxt   = '0;
              w_side_nxt  = (r_state == StFlat);
              w_price_nxt = price;
              w_state_nxt = (r_state == StFlat) ? StPendBuy : StPendSell;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            // HOLD, illegal, or a non-actionable direction breaks the run.
            w_cnt_nxt = '0;
          end
        end
      end
      StPendBuy, StPendSell: begin
`ifdef IC_ORDER_TIMEOUT_EN
        w_wait_nxt = r_wait + 16'd1;
`endif
        if (order_ready) begin
          w_long_nxt  = (r_state == StPendBuy);
          w_state_nxt = StCool;
          w_cool_nxt  = CooldownW;
        end
`ifdef IC_ORDER_TIMEOUT_EN
        else if (r_wait == TmoLast) begin
          w_state_nxt = w_rest_state;
        end
`endif
      end
      StCool: begin
        if (r_cool == 8'd0) begin
          w_state_nxt = w_rest_state;
        end else begin
          w_cool_nxt = r_cool - 8'd1;
        end
      end
      default: w_state_nxt = StFlat;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StFlat;
      r_cnt   <= '0;
      r_cool  <= '0;
      r_last  <= CodeHold;
      r_side  <= 1'b0;
      r_price <= '0;
      r_long  <= 1'b0;
      r_err   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cool  <= w_cool_nxt;
      r_last  <= w_last_nxt;
      r_side  <= w_side_nxt;
      r_price <= w_price_nxt;
      r_long  <= w_long_nxt;
      r_err   <= w_err_nxt;
    end
  end

`ifdef IC_ORDER_TIMEOUT_EN
  // Cycles spent waiting for order_ready in the current pending order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else begin
      r_wait <= w_wait_nxt;
    end
  end
`endif

  // Outputs come straight from state so reset clears them asynchronously.
  always_comb begin
    order_valid = (r_state == StPendBuy) || (r_state == StPendSell);
    order_side  = r_side;
    order_qty   = order_valid ? QTY : 16'd0;
    order_price = r_price;
    long_pos    = r_long;
    err_cnt     = r_err;
  end

endmodule

// File: tb/tb_ic_order_gen.sv
// Directed self-checking bench for ic_order_gen (default parameters).
module tb_ic_order_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_valid;
  logic        sig_out1;
  logic        sig_out2;
  logic [31:0] price;
  logic        order_ready;
  logic        order_valid;
  logic        order_side;
  logic [15:0] order_qty;
  logic [31:0] order_price;
  logic        long_pos;
  logic [7:0]  err_cnt;

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [1:0] BUY = 2'b10, SELL = 2'b00, HOLD = 2'b01, ILL = 2'b11;

  ic_order_gen dut (
    .clk        (clk),
    .rst        (rst),
    .sig_valid  (sig_valid),
    .sig_out1   (sig_out1),
    .sig_out2   (sig_out2),
    .price      (price),
    .order_ready(order_ready),
    .order_valid(order_valid),
    .order_side (order_side),
    .order_qty  (order_qty),
    .order_price(order_price),
    .long_pos   (long_pos),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [1:0] code, input logic [31:0] p);
    sig_valid = 1'b1;
    {sig_out1, sig_out2} = code;
    price = p;
    tick();
    sig_valid = 1'b0;
    {sig_out1, sig_out2} = HOLD;
  endtask

  initial begin
    int hi;
    sig_valid = 1'b0;
    sig_out1 = 1'b0;
    sig_out2 = 1'b1;
    price = '0;
    order_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_valid", order_valid, 0);
    chk("rst_long", long_pos, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_qty", order_qty, 0);
    chk("rst_price", order_price, 0);
    chk("rst_side", order_side, 0);
    wait_n(2);
    rst = 1'b0;
    tick();

    // Test 1: three BUYs with ready held high
    order_ready = 1'b1;
    send(BUY, 32'h42280000);
    send(BUY, 32'h42280000);
    chk("t1_no_early", order_valid, 0);
    chk("t1_ready_ignored", long_pos, 0);
    send(BUY, 32'h42280000);
    chk("t1_valid", order_valid, 1);
    chk("t1_side", order_side, 1);
    chk("t1_qty", order_qty, 16'd100);
    chk("t1_price", order_price, 32'h42280000);
    tick();
    chk("t1_one_cycle", order_valid, 0);
    chk("t1_long", long_pos, 1);
    // Samples during cooldown are ignored
    for (int i = 0; i < 3; i++) begin
      send(SELL, 32'h40000000);
      chk("t1_cool_no_order", order_valid, 0);
    end
    wait_n(3);
    chk("t1_cool_long", long_pos, 1);

    // Test 3: SELL from LONG, ready held low, PEND ignores samples
    order_ready = 1'b0;
    send(SELL, 32'h41200000);
    send(SELL, 32'h41200000);
    chk("t3_no_early", order_valid, 0);
    send(SELL, 32'h41200000);
    chk("t3_valid", order_valid, 1);
    chk("t3_side", order_side, 0);
    sig_valid = 1'b1;
    {sig_out1, sig_out2} = ILL;
    price = 32'hDEADBEEF;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_valid", order_valid, 1);
      chk("t3_hold_price", order_price, 32'h41200000);
      chk("t3_hold_side", order_side, 0);
      chk("t3_hold_qty", order_qty, 16'd100);
    end
    order_ready = 1'b1;
    tick();
    sig_valid = 1'b0;
    {sig_out1, sig_out2} = HOLD;
    order_ready = 1'b0;
    chk("t3_xfer_valid", order_valid, 0);
    chk("t3_xfer_long", long_pos, 0);
    chk("t3_pend_no_err", err_cnt, 0);
    wait_n(6);

    // Illegal codes in FLAT count and act as HOLD
    send(ILL, 32'h0);
    send(ILL, 32'h0);
    send(BUY, 32'h1);
    send(BUY, 32'h2);
    send(ILL, 32'h0);
    chk("ill_err3", err_cnt, 3);
    chk("ill_no_order", order_valid, 0);

    // Test 2: BUY BUY HOLD BUY BUY BUY
    send(BUY, 32'h11);
    chk("t2_s1", order_valid, 0);
    send(BUY, 32'h12);
    chk("t2_s2", order_valid, 0);
    send(HOLD, 32'h13);
    chk("t2_s3", order_valid, 0);
    send(BUY, 32'h14);
    chk("t2_s4", order_valid, 0);
    send(BUY, 32'h15);
    chk("t2_s5", order_valid, 0);
    send(BUY, 32'h16);
    chk("t2_s6_valid", order_valid, 1);
    chk("t2_s6_side", order_side, 1);
    chk("t2_s6_price", order_price, 32'h16);
    order_ready = 1'b1;
    tick();
    order_ready = 1'b0;
    chk("t2_xfer_long", long_pos, 1);
    wait_n(6);

    // err_cnt saturation
    for (int i = 0; i < 251; i++) send(ILL, 32'h0);
    chk("sat_254", err_cnt, 254);
    send(ILL, 32'h0);
    chk("sat_255", err_cnt, 255);
    for (int i = 0; i < 48; i++) send(ILL, 32'h0);
    chk("sat_hold", err_cnt, 255);
    chk("sat_no_order", order_valid, 0);

    // Back to FLAT
    order_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(SELL, 32'h3);
    chk("flat_sell_valid", order_valid, 1);
    tick();
    chk("flat_long", long_pos, 0);
    wait_n(6);

    // Async reset during PEND_BUY
    order_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(BUY, 32'h55);
    chk("rp_valid", order_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rp_async_valid", order_valid, 0);
    chk("rp_async_long", long_pos, 0);
    chk("rp_async_err", err_cnt, 0);
    chk("rp_async_price", order_price, 0);
    #2 rst = 1'b0;
    order_ready = 1'b1;
    wait_n(3);
    chk("rp_no_xfer_valid", order_valid, 0);
    chk("rp_no_xfer_long", long_pos, 0);
    order_ready = 1'b0;

`ifdef IC_ORDER_TIMEOUT_EN
    // Timeout abandons the order after 16 cycles
    for (int i = 0; i < 3; i++) send(BUY, 32'h77);
    hi = order_valid ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (order_valid) hi++;
    end
    chk("tmo_cycles", hi, 16);
    chk("tmo_valid", order_valid, 0);
    chk("tmo_long", long_pos, 0);
    order_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(BUY, 32'h78);
    chk("tmo_reissue_valid", order_valid, 1);
    chk("tmo_reissue_price", order_price, 32'h78);
    tick();
    chk("tmo_reissue_long", long_pos, 1);
    order_ready = 1'b0;
`else
    hi = 0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ic_order_gen.md
Name: ic_order_gen

Overview:
- Consumer side of the Ichimoku signal pair: samples the two-wire trade signal (buy / sell / hold) plus the current price.
- Confirms the signal over consecutive samples and tracks a long/flat position.
- Issues single-lot orders to the downstream order port over a valid/ready handshake.
- Sits between the generated signal module and the exchange-side order encoder.

Parameters:
- CONFIRM, 3, consecutive identical actionable samples required before an order is raised (1..15).
- COOLDOWN, 4, clk cycles after an accepted order during which samples are ignored (0..255).
- QTY, 16'd100, order quantity driven on order_qty.
- TIMEOUT, 16, cycles an order may wait for order_ready (used only with the optional feature).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- sig_valid  input  1  one-cycle strobe; sig_out1/sig_out2/price are sampled on this cycle
- sig_out1  input  1  signal bit 1 (10=BUY, 00=SELL, 01=HOLD, 11=illegal)
- sig_out2  input  1  signal bit 2
- price  input  32  IEEE-754 single price captured with the sample
- order_ready  input  1  downstream accepts order this cycle
- order_valid  output  1  order pending
- order_side  output  1  1=buy, 0=sell
- order_qty  output  16  quantity, constant QTY while order_valid
- order_price  output  32  price of the confirming sample
- long_pos  output  1  1=holding position
- err_cnt  output  8  count of illegal (11) samples, saturating at 255

Behaviour:
- Reset (asynchronous, active-high): all outputs 0; state FLAT; confirm counter 0; cooldown counter 0; last-candidate register = HOLD.
- States: FLAT, LONG, PEND_BUY, PEND_SELL, COOL.
- Sample decode: a sample is taken only when sig_valid=1 and state is FLAT or LONG.
  - Illegal code 11 increments err_cnt and is treated as HOLD.
- Actionable candidate: BUY in FLAT, SELL in LONG. All other samples (HOLD, BUY while LONG, SELL while FLAT) clear the confirm counter to 0.
- Confirm counter:
  - Increments on each actionable sample equal to the previous candidate.
  - Resets to 1 when the candidate changes.
- When the count reaches CONFIRM on a sample, the next cycle enters PEND_BUY or PEND_SELL:
  - order_valid=1, order_side set, order_price = price of that sample.
  - Confirm counter cleared.
  - Latency: order_valid rises 1 cycle after the confirming sig_valid.
- Handshake:
  - order_side, order_qty and order_price are stable while order_valid=1.
  - Transfer occurs on the edge where order_valid & order_ready.
  - order_ready while order_valid=0 is ignored.
  - Back-to-back orders are impossible; COOL always intervenes.
- On transfer:
  - order_valid drops the next cycle.
  - long_pos toggles the same edge (PEND_BUY sets it, PEND_SELL clears it).
  - State enters COOL with the counter loaded with COOLDOWN.
- COOL: decrements each cycle and ignores sig_valid. At 0 it enters LONG or FLAT per long_pos. COOLDOWN=0 returns immediately (one cycle in COOL).
- PEND states ignore sig_valid entirely; no sample or err_cnt update occurs.
- sig_valid and the transfer in the same cycle: the sample is ignored.
- Reset asserted mid-pending: the order is dropped, long_pos=0, and no transfer is reported.

Optional Feature:
- Macro IC_ORDER_TIMEOUT_EN.
- Defined:
  - A wait counter runs while in PEND_*.
  - If TIMEOUT cycles elapse without order_ready, order_valid drops and the state returns to FLAT/LONG unchanged; long_pos is not modified and the confirm counter is 0.
  - A transfer on the final cycle (count = TIMEOUT-1 with order_ready=1) wins over the timeout.
- Undefined: the order is held indefinitely until order_ready.

Test Plan:
- Reset release, then three sig_valid samples of code 10 at price 0x42280000 with order_ready=1 -> order_valid=1 for exactly 1 cycle, side=1, qty=100, price=0x42280000; long_pos=1; no further order for 4 cycles.
- From FLAT: BUY, BUY, HOLD, BUY, BUY, BUY -> exactly one buy order, raised after the 6th sample.
- From LONG: three SELL samples with order_ready held low for 10 cycles, then high -> order_valid stays high with stable payload for 10 cycles; transfer on cycle 11; long_pos=0.
- Samples of code 11 ×3 in FLAT -> err_cnt=3, no order; 300 illegal samples -> err_cnt=255.
- Reset asserted during PEND_BUY -> order_valid=0 and long_pos=0 immediately, without waiting for a clock edge.
- IC_ORDER_TIMEOUT_EN with TIMEOUT=16 and order_ready held 0 -> order_valid deasserts after 16 cycles; long_pos unchanged; a fresh 3-sample confirm reissues the order.
